icache_ctrl: RTL and testbench
==============================

ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, fetch address width.
REQ-002 Parameter TAG_W, default 21, tag field width (ADDR_W - 7 index - 4 offset).
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_req_valid / o_req_ready / i_req_addr[ADDR_W-1:0]: fetch request handshake.
REQ-006 o_rsp_valid / i_rsp_ready / o_rsp_inst[31:0]: fetch response handshake.
REQ-007 i_fencei  in  1  invalidate-all request pulse; o_fencei_done  out  1  one-cycle completion pulse.
REQ-008 o_tag_wen, o_tag_invalid, o_tag_addr[6:0], o_tag_din[63:0], i_tag_dout[63:0]: tag-array port; read data combinational from o_tag_addr.
REQ-009 o_data_wen, o_data_addr[7:0] ({index, word}), o_data_din[63:0], i_data_dout[63:0]: data-array port, combinational read.
REQ-010 o_mem_ar_valid / i_mem_ar_ready / o_mem_ar_addr[ADDR_W-1:0]: refill address channel.
REQ-011 i_mem_r_valid / o_mem_r_ready / i_mem_r_data[63:0] / i_mem_r_last: refill data channel.

Function
REQ-012 Direct-mapped, 128 sets, 16-byte line = 2 x 64-bit words; index = addr[10:4], word = addr[3], half = addr[2], tag = addr[ADDR_W-1:11]; addr[1:0] ignored.
REQ-013 FSM states IDLE, LOOKUP, MISS_AR, MISS_R, RESP.
REQ-014 IDLE: o_req_ready = ~i_fencei; request handshake latches address, -> LOOKUP.
REQ-015 IDLE with i_fencei: one-cycle o_tag_invalid, o_fencei_done same cycle, stay IDLE; fencei wins over simultaneous request (request not accepted).
REQ-016 i_fencei outside IDLE held pending in a flag; serviced on first IDLE cycle, before any new request.
REQ-017 LOOKUP: hit = tag valid bit (bit 63) set and tag field [TAG_W-1:0] equals latched tag; hit -> RESP with selected 32-bit half registered; miss -> MISS_AR.
REQ-018 Hit latency: response valid 2 cycles after request handshake.
REQ-019 MISS_AR: o_mem_ar_valid=1, o_mem_ar_addr = latched address with [3:0] zeroed; held stable until i_mem_ar_ready, -> MISS_R.
REQ-020 MISS_R: o_mem_r_ready=1; each beat writes o_data_din=i_mem_r_data to word beat_cnt (1-bit, from 0); counter increments per beat.
REQ-021 Beat with i_mem_r_last: also writes tag {valid=1, latched tag}, counter cleared, -> LOOKUP (re-lookup hits).
REQ-022 Miss latency: exactly LOOKUP re-entry the cycle after last beat; no response data forwarded from refill beats.
REQ-023 RESP: o_rsp_valid=1, o_rsp_inst stable until i_rsp_ready; handshake -> IDLE.
REQ-024 o_tag_wen and o_data_wen never asserted outside MISS_R; o_tag_invalid never with o_tag_wen.
REQ-025 r-beats without r_last beyond 2 wrap beat_cnt to 0 (overwrite); no error flagged.

Reset
REQ-026 On i_rst: state IDLE, beat_cnt 0, fencei-pending 0, latched address 0.
REQ-027 Outputs during/after reset: all valid/wen/invalid/done 0, o_req_ready 1, o_rsp_inst 0.
REQ-028 Reset mid-refill abandons the line; tag not written; memory side is reset by the same reset.
REQ-029 Controller does not clear tag array on reset; tag array owns its own reset.

Structure
REQ-030 Package icache_pkg holds VLD_BIT (63), TAG_BIT range, index/offset widths, state enum.
REQ-031 No sub-module; tag and data arrays instantiated by the parent, connected to the ports above.

Verification
REQ-032 Cold miss: reset, req 0x8000_0004 -> AR addr 0x8000_0000; beats 0x1111_2222_3333_4444, 0x5555_6666_7777_8888(last) -> inst 0x1111_2222.
REQ-033 Hit: after REQ-032, req 0x8000_000C -> o_rsp_valid 2 cycles after handshake, inst 0x5555_6666, no AR.
REQ-034 Conflict: req 0x8000_0800 (same index, other tag) -> miss, refill, tag overwritten; 0x8000_0000 then misses.
REQ-035 Fence.i with simultaneous req in IDLE -> o_tag_invalid and o_fencei_done one cycle, req_ready 0; next 0x8000_000C misses.
REQ-036 Backpressure: i_rsp_ready low 5 cycles -> o_rsp_inst stable; ar_ready low 3 cycles -> ar_addr stable.
REQ-037 Reset after first refill beat -> IDLE, no tag write, next same req misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache controller.
// Geometry: 128 sets of 16-byte lines, each line held as two 64-bit words.
package icache_pkg;
    localparam int IDX_W   = 7;
    localparam int OFF_W   = 4;
    localparam int VLD_BIT = 63;
    localparam int TAG_LSB = 0;
    localparam int TAG_MAX = 62;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_MISS_AR = 3'd2,
        ST_MISS_R  = 3'd3,
        ST_RESP    = 3'd4
    } state_e;
endpackage

// File: rtl/icache_ctrl.sv
// Instruction cache controller: lookup, two-beat line refill, fence.i invalidate-all.
// Tag and data arrays live in the parent; this block drives their ports only.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 21
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_inst,
    input  logic              i_fencei,
    output logic              o_fencei_done,
    output logic              o_tag_wen,
    output logic              o_tag_invalid,
    output logic [6:0]        o_tag_addr,
    output logic [63:0]       o_tag_din,
    input  logic [63:0]       i_tag_dout,
    output logic              o_data_wen,
    output logic [7:0]        o_data_addr,
    output logic [63:0]       o_data_din,
    input  logic [63:0]       i_data_dout,
    output logic              o_mem_ar_valid,
    input  logic              i_mem_ar_ready,
    output logic [ADDR_W-1:0] o_mem_ar_addr,
    input  logic              i_mem_r_valid,
    output logic              o_mem_r_ready,
    input  logic [63:0]       i_mem_r_data,
    input  logic              i_mem_r_last
);

    state_e            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_beat_cnt;
    logic              r_fence_pend;
    logic [31:0]       r_rsp_inst;

    logic              w_idle;
    logic              w_fence_svc;
    logic              w_hit;
    logic              w_beat;
    logic              w_word;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_unused;

    assign w_idle = (r_state == ST_IDLE);
    assign w_idx  = r_addr[OFF_W +: IDX_W];
    assign w_tag  = r_addr[ADDR_W-1 -: TAG_W];

    // A pending or fresh fence.i is serviced in IDLE ahead of any request.
    assign w_fence_svc   = w_idle && (i_fencei || r_fence_pend) && !i_rst;
    assign o_req_ready   = i_rst || (w_idle && !i_fencei && !r_fence_pend);
    assign o_tag_invalid = w_fence_svc;
    assign o_fencei_done = w_fence_svc;

    assign w_hit = i_tag_dout[VLD_BIT] && (i_tag_dout[TAG_LSB +: TAG_W] == w_tag);

    assign o_mem_ar_valid = (r_state == ST_MISS_AR) && !i_rst;
    assign o_mem_ar_addr  = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign o_mem_r_ready  = (r_state == ST_MISS_R) && !i_rst;
    assign w_beat         = o_mem_r_ready && i_mem_r_valid;

    assign w_word      = (r_state == ST_MISS_R) ? r_beat_cnt : r_addr[3];
    assign o_tag_addr  = w_idx;
    assign o_tag_wen   = w_beat && i_mem_r_last;
    assign o_tag_din   = {1'b1, {(VLD_BIT-TAG_W){1'b0}}, w_tag};
    assign o_data_wen  = w_beat;
    assign o_data_addr = {w_idx, w_word};
    assign o_data_din  = i_mem_r_data;

    assign o_rsp_valid = (r_state == ST_RESP) && !i_rst;
    assign o_rsp_inst  = r_rsp_inst;

    assign w_unused = ^{i_tag_dout[TAG_MAX:TAG_W], r_addr[1:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_beat_cnt   <= 1'b0;
            r_fence_pend <= 1'b0;
            r_rsp_inst   <= '0;
        end else begin
            if (!w_idle && i_fencei) begin
                r_fence_pend <= 1'b1;
            end else if (w_fence_svc) begin
                r_fence_pend <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        r_addr  <= i_req_addr;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_rsp_inst <= r_addr[2] ? i_data_dout[63:32] : i_data_dout[31:0];
                        r_state    <= ST_RESP;
                    end else begin
                        r_state <= ST_MISS_AR;
                    end
                end
                ST_MISS_AR: begin
                    if (i_mem_ar_ready) begin
                        r_state <= ST_MISS_R;
                    end
                end
                // Refill data is not forwarded; the re-lookup after the last beat hits.
                ST_MISS_R: begin
                    if (i_mem_r_valid) begin
                        if (i_mem_r_last) begin
                            r_beat_cnt <= 1'b0;
                            r_state    <= ST_LOOKUP;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: behavioural tag/data arrays, a refill memory responder and a response scoreboard.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic        fencei;
    logic        fencei_done;
    logic        tag_wen;
    logic        tag_invalid;
    logic [6:0]  tag_addr;
    logic [63:0] tag_din;
    logic [63:0] tag_dout;
    logic        data_wen;
    logic [7:0]  data_addr;
    logic [63:0] data_din;
    logic [63:0] data_dout;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic        r_valid;
    logic        r_ready;
    logic [63:0] r_data;
    logic        r_last;

    logic [63:0] tag_mem  [128];
    logic [63:0] data_mem [256];
    logic        tarr_rst;

    int n_chk  = 0;
    int n_pass = 0;
    int ar_count = 0;
    int beats_acc = 0;
    int viol = 0;
    int ar_stall = 0;
    logic [31:0] exp_ar = '0;
    logic [31:0] exp_q[$];

    int          resp_st;
    int          resp_stall;
    logic [31:0] resp_a;

    typedef struct {
        logic [31:0] addr;
        logic        miss;
        logic [31:0] inst;
        int          rstall;
        int          astall;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    icache_ctrl #(.ADDR_W(32), .TAG_W(21)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_inst(rsp_inst),
        .i_fencei(fencei), .o_fencei_done(fencei_done),
        .o_tag_wen(tag_wen), .o_tag_invalid(tag_invalid), .o_tag_addr(tag_addr),
        .o_tag_din(tag_din), .i_tag_dout(tag_dout),
        .o_data_wen(data_wen), .o_data_addr(data_addr), .o_data_din(data_din),
        .i_data_dout(data_dout),
        .o_mem_ar_valid(ar_valid), .i_mem_ar_ready(ar_ready), .o_mem_ar_addr(ar_addr),
        .i_mem_r_valid(r_valid), .o_mem_r_ready(r_ready), .i_mem_r_data(r_data),
        .i_mem_r_last(r_last)
    );

    // Tag array keeps its contents across controller reset; only tarr_rst clears it.
    assign tag_dout  = tag_mem[tag_addr];
    assign data_dout = data_mem[data_addr];

    always @(posedge clk) begin
        if (tarr_rst || tag_invalid) begin
            for (int i = 0; i < 128; i++) tag_mem[i] <= '0;
        end else if (tag_wen) begin
            tag_mem[tag_addr] <= tag_din;
        end
        if (data_wen) data_mem[data_addr] <= data_din;
        if (!rst && r_ready && r_valid) beats_acc <= beats_acc + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if ((tag_invalid && tag_wen) || ((tag_wen || data_wen) && !r_ready)) viol <= viol + 1;
        end
    end

    function automatic logic [63:0] mem64(input logic [31:0] a);
        if (a == 32'h8000_0000) return 64'h1111_2222_3333_4444;
        if (a == 32'h8000_0008) return 64'h5555_6666_7777_8888;
        return {~a, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    initial begin : responder
        resp_st = 0; resp_stall = 0; resp_a = '0;
        ar_ready = 0; r_valid = 0; r_data = '0; r_last = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                resp_st = 0; ar_ready = 0; r_valid = 0; r_last = 0;
            end else begin
                case (resp_st)
                    0: if (ar_valid) begin
                        resp_a = ar_addr;
                        ar_count++;
                        chk("ar_addr", resp_a, exp_ar);
                        resp_stall = ar_stall;
                        if (resp_stall == 0) begin ar_ready = 1; resp_st = 1; end
                        else resp_st = 3;
                    end
                    3: begin
                        chk("ar_hold", {ar_valid, ar_addr}, {1'b1, resp_a});
                        resp_stall--;
                        if (resp_stall == 0) begin ar_ready = 1; resp_st = 1; end
                    end
                    1: begin
                        ar_ready = 0; r_valid = 1; r_data = mem64(resp_a); r_last = 0; resp_st = 2;
                    end
                    2: begin
                        if (!r_last) begin r_data = mem64(resp_a + 32'd8); r_last = 1; end
                        else begin r_valid = 0; r_last = 0; resp_st = 0; end
                    end
                    default: resp_st = 0;
                endcase
            end
        end
    end

    task automatic send_req(input logic [31:0] a, input logic miss, input logic [31:0] inst,
                            input int rstall, input int astall);
        int ar0, lat;
        bit ok;
        logic [31:0] first, exp_inst;
        ar0 = ar_count; ar_stall = astall; exp_ar = {a[31:4], 4'h0};
        @(negedge clk);
        req_valid = 1; req_addr = a;
        exp_q.push_back(inst);
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("req_accept", ok, 1);
        if (!ok) begin req_valid = 0; void'(exp_q.pop_back()); return; end
        @(posedge clk); #1 req_valid = 0;
        lat = 0; ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); lat++;
            if (rsp_valid) begin ok = 1; break; end
        end
        chk("rsp_arrive", ok, 1);
        if (!ok) begin void'(exp_q.pop_front()); return; end
        if (!miss) chk("hit_latency", lat, 2);
        chk("ar_issued", ar_count - ar0, miss ? 1 : 0);
        first = rsp_inst;
        for (int n = 0; n < rstall; n++) begin
            @(negedge clk);
            chk("rsp_hold", {rsp_valid, rsp_inst}, {1'b1, first});
        end
        exp_inst = exp_q.pop_front();
        chk("rsp_inst", rsp_inst, exp_inst);
        rsp_ready = 1;
        @(posedge clk); #1 rsp_ready = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        bit ok;
        int b0;
        logic [31:0] e;
        vecs[0]  = '{32'h8000_0004, 1'b1, 32'h1111_2222, 0, 0};
        vecs[1]  = '{32'h8000_000C, 1'b0, 32'h5555_6666, 0, 0};
        vecs[2]  = '{32'h8000_0000, 1'b0, 32'h3333_4444, 0, 0};
        vecs[3]  = '{32'h8000_0008, 1'b0, 32'h7777_8888, 5, 0};
        vecs[4]  = '{32'h8000_0800, 1'b1, 32'h8000_0800, 0, 0};
        vecs[5]  = '{32'h8000_0804, 1'b0, 32'h7FFF_F7FF, 0, 0};
        vecs[6]  = '{32'h8000_0000, 1'b1, 32'h3333_4444, 0, 3};
        vecs[7]  = '{32'h0000_1234, 1'b1, 32'hFFFF_EDCF, 0, 0};
        vecs[8]  = '{32'h0000_123C, 1'b0, 32'hFFFF_EDC7, 0, 0};
        vecs[9]  = '{32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF8, 0, 0};
        vecs[10] = '{32'hFFFF_FFFB, 1'b0, 32'hFFFF_FFF8, 2, 0};

        rst = 1; tarr_rst = 1; req_valid = 0; req_addr = '0; rsp_ready = 0; fencei = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ar_valid", ar_valid, 0);
        chk("rst_wen", {tag_wen, data_wen, tag_invalid, fencei_done}, 0);
        chk("rst_rsp_inst", rsp_inst, 0);
        rst = 0; tarr_rst = 0;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_valids", {rsp_valid, ar_valid, r_ready}, 0);

        for (int i = 0; i < 11; i++)
            send_req(vecs[i].addr, vecs[i].miss, vecs[i].inst, vecs[i].rstall, vecs[i].astall);

        // fence.i collides with a request while idle
        @(negedge clk);
        fencei = 1; req_valid = 1; req_addr = 32'h8000_000C;
        #1;
        chk("fence_req_ready", req_ready, 0);
        chk("fence_invalid", tag_invalid, 1);
        chk("fence_done", fencei_done, 1);
        chk("fence_no_tag_wen", tag_wen, 0);
        @(posedge clk); #1 fencei = 0; req_valid = 0;
        @(negedge clk);
        chk("fence_pulse_end", {tag_invalid, fencei_done}, 0);
        chk("fence_req_dropped", req_ready, 1);
        @(negedge clk);
        chk("fence_still_idle", {req_ready, rsp_valid}, 2'b10);
        send_req(32'h8000_000C, 1'b1, 32'h5555_6666, 0, 0);

        // fence.i arriving mid-transaction waits for IDLE
        @(negedge clk);
        req_valid = 1; req_addr = 32'h8000_0004;
        exp_q.push_back(32'h1111_2222);
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk);
        fencei = 1;
        #1;
        chk("pend_no_done_busy", fencei_done, 0);
        @(posedge clk); #1 fencei = 0;
        @(negedge clk);
        chk("pend_rsp_valid", rsp_valid, 1);
        chk("pend_no_invalid", tag_invalid, 0);
        e = exp_q.pop_front();
        chk("pend_rsp_inst", rsp_inst, e);
        rsp_ready = 1;
        @(posedge clk); #1 rsp_ready = 0;
        @(negedge clk);
        chk("pend_done", {fencei_done, tag_invalid, req_ready}, 3'b110);
        @(negedge clk);
        chk("pend_cleared", {fencei_done, tag_invalid, req_ready}, 3'b001);
        send_req(32'h8000_0004, 1'b1, 32'h1111_2222, 0, 0);

        // reset after the first refill beat abandons the line
        b0 = beats_acc; exp_ar = 32'h0000_1230; ar_stall = 0;
        @(negedge clk);
        req_valid = 1; req_addr = 32'h0000_1234;
        @(posedge clk); #1 req_valid = 0;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (beats_acc == b0 + 1) begin ok = 1; break; end
        end
        chk("midfill_first_beat", ok, 1);
        rst = 1;
        @(negedge clk);
        chk("midfill_rst_outputs", {req_ready, r_ready, tag_wen, rsp_valid}, 4'b1000);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("midfill_after_rst", {req_ready, ar_valid, rsp_valid}, 3'b100);
        chk("midfill_rsp_inst", rsp_inst, 0);
        send_req(32'h0000_1234, 1'b1, 32'hFFFF_EDCF, 0, 0);

        repeat (2) @(negedge clk);
        chk("no_illegal_wen", viol, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
